// File: rtl/riscv_dmem_bridge.sv
// Data-memory bridge between the core MEM stage and a req/gnt + rvalid bus.
// One load/store in, one bus transaction out; the core is stalled until it completes.
module riscv_dmem_bridge #(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_misalign,
    output logic                  rsp_fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [XLEN-1:0]       bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [XLEN-1:0]       bus_rdata,
    input  logic                  bus_err
);

    // state  | meaning
    // IDLE   | waiting for req_valid; decode and capture the access
    // REQ    | bus_req high, fields held until bus_gnt
    // RSP    | waiting for bus_rvalid (data or store ack)
    // DONE   | one-cycle rsp_valid with result/flags, stall low
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    logic                  capture, take_rsp, take_timeout, timeout_hit;
    logic [15:0]           cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  write_q;
    logic [3:0]            be_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       rdata_q;
    logic                  misal_q, fault_q;

    logic                  dec_legal, dec_misalign;
    logic [3:0]            dec_be;
    logic [XLEN-1:0]       dec_wdata;
    logic [XLEN-1:0]       rd_shift, load_ext;

    // Request decode; unsigned load codes are illegal for stores.
    always_comb begin
        dec_legal    = 1'b0;
        dec_misalign = 1'b0;
        dec_be       = 4'b0000;
        dec_wdata    = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: begin
                dec_legal = (req_funct3 == 3'b000) || !req_write;
                dec_be    = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                dec_legal    = (req_funct3 == 3'b001) || !req_write;
                dec_misalign = req_addr[0];
                dec_be       = 4'b0011 << req_addr[1:0];
                dec_wdata    = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                dec_legal    = 1'b1;
                dec_misalign = |req_addr[1:0];
                dec_be       = 4'b1111;
            end
            default: ;
        endcase
        dec_misalign = dec_misalign & dec_legal;
    end

    assign rd_shift = bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = bus_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        take_rsp     = 1'b0;
        take_timeout = 1'b0;
        stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    capture = 1'b1;
                    state_d = (dec_legal && !dec_misalign) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (timeout_hit) begin
                    take_timeout = 1'b1;
                    state_d      = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                stall = 1'b1;
                // A response arriving on the last allowed cycle still wins.
                if (bus_rvalid) begin
                    take_rsp = 1'b1;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= 16'd0;
        end else if (state_q == S_REQ || state_q == S_RSP) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            funct3_q <= 3'd0;
            write_q  <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            misal_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else if (capture) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            be_q     <= dec_be;
            wdata_q  <= dec_wdata;
            rdata_q  <= '0;
            misal_q  <= dec_misalign;
            fault_q  <= !dec_legal;
        end else if (take_rsp) begin
            fault_q <= bus_err;
            rdata_q <= (bus_err || write_q) ? '0 : load_ext;
        end else if (take_timeout) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
        end
    end

    assign bus_req      = (state_q == S_REQ);
    assign bus_we       = write_q;
    assign bus_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;
    assign rsp_valid    = (state_q == S_DONE);
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign rsp_misalign = rsp_valid & misal_q;
    assign rsp_fault    = rsp_valid & fault_q;

endmodule
